// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, Status/Cause bit positions and exception codes.
package cp0_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    localparam int unsigned IE          = 0;
    localparam int unsigned EXL         = 1;
    localparam int unsigned IM_LSB      = 8;
    localparam int unsigned IP_LSB      = 8;
    localparam int unsigned EXCCODE_LSB = 2;

    typedef enum logic [4:0] {
        INT = 5'd0,
        SYS = 5'd8,
        OV  = 5'd12
    } exc_code_t;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with sticky TI flag; removed entirely when TIMER_EN is 0.
module cp0_timer
    import cp0_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter bit          TIMER_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_c0W,
    input  logic [4:0]        writeregW,
    input  logic [DATA_W-1:0] resultW,
    output logic [DATA_W-1:0] count,
    output logic [DATA_W-1:0] compare,
    output logic              ti
);

    if (TIMER_EN) begin : g_timer
        localparam logic [DATA_W-1:0] One = DATA_W'(1);

        logic [DATA_W-1:0] count_q, count_d;
        logic [DATA_W-1:0] compare_q, compare_d;
        logic              ti_q, ti_d;
        logic              wr_count, wr_compare;

        always_comb begin
            wr_count   = write_c0W && (writeregW == CP0_COUNT);
            wr_compare = write_c0W && (writeregW == CP0_COMPARE);
            count_d    = wr_count ? resultW : count_q + One;
            compare_d  = wr_compare ? resultW : compare_q;
            // Match uses the pre-increment count; a Compare write acknowledges TI.
            ti_d       = wr_compare ? 1'b0 : (ti_q | (count_q == compare_q));
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                count_q   <= '0;
                compare_q <= '1;
                ti_q      <= 1'b0;
            end else begin
                count_q   <= count_d;
                compare_q <= compare_d;
                ti_q      <= ti_d;
            end
        end

        assign count   = count_q;
        assign compare = compare_q;
        assign ti      = ti_q;
    end else begin : g_no_timer
        logic unused_timer;
        assign unused_timer = ^{clk, reset, write_c0W, writeregW, resultW};
        assign count   = '0;
        assign compare = '0;
        assign ti      = 1'b0;
    end

endmodule

// File: rtl/cp0_intc.sv
// Coprocessor 0 with Status/Cause/EPC, N_IRQ masked interrupt lines and exception arbitration.
module cp0_intc
    import cp0_pkg::*;
#(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       N_IRQ      = 6,
    parameter logic [DATA_W-1:0] EXC_VECTOR = 32'h0000_0180,
    parameter bit                TIMER_EN   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_c0W,
    input  logic [4:0]        writeregW,
    input  logic [DATA_W-1:0] resultW,
    input  logic [4:0]        rd_sel,
    output logic [DATA_W-1:0] c0D,
    input  logic              exc_req,
    input  logic [4:0]        exc_code,
    input  logic [DATA_W-1:0] exc_pc,
    input  logic [DATA_W-1:0] int_pc,
    input  logic [N_IRQ-1:0]  irq,
    input  logic              eret,
    output logic              take_exc,
    output logic [DATA_W-1:0] exc_vector,
    output logic [DATA_W-1:0] epc,
    output logic              kernel_mode
);

    logic              ie_q, ie_d;
    logic              exl_q, exl_d;
    logic [N_IRQ:0]    im_q, im_d;
    logic [N_IRQ-1:0]  ip_q;
    logic [4:0]        exc_code_q, exc_code_d;
    logic [DATA_W-1:0] epc_q, epc_d;
    logic              take_q, take_d;

    logic [DATA_W-1:0] count, compare;
    logic              ti;
    logic              wr_status, wr_epc;
    logic              int_pend, exc_take, int_take;
    logic [DATA_W-1:0] status_rd, cause_rd;

    cp0_timer #(
        .DATA_W   (DATA_W),
        .TIMER_EN (TIMER_EN)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .write_c0W (write_c0W),
        .writeregW (writeregW),
        .resultW   (resultW),
        .count     (count),
        .compare   (compare),
        .ti        (ti)
    );

    always_comb begin
        wr_status = write_c0W && (writeregW == CP0_STATUS);
        wr_epc    = write_c0W && (writeregW == CP0_EPC);
        int_pend  = ie_q & ~exl_q & (|({ti, ip_q} & im_q));
        exc_take  = exc_req & ~exl_q;
        int_take  = int_pend & ~exc_take;
        take_d    = exc_take | int_take;

        ie_d       = ie_q;
        exl_d      = exl_q;
        im_d       = im_q;
        epc_d      = epc_q;
        exc_code_d = exc_code_q;

        if (wr_status) begin
            ie_d  = resultW[IE];
            exl_d = resultW[EXL];
            im_d  = resultW[IM_LSB +: N_IRQ+1];
        end
        if (wr_epc) begin
            epc_d = resultW;
        end

        // Hardware events override any same-cycle software write of EXL/EPC/ExcCode.
        if (exc_take) begin
            epc_d      = exc_pc;
            exc_code_d = exc_code;
            exl_d      = 1'b1;
        end else if (int_take) begin
            epc_d      = int_pc;
            exc_code_d = INT;
            exl_d      = 1'b1;
        end else if (eret && exl_q) begin
            exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ie_q       <= 1'b0;
            exl_q      <= 1'b0;
            im_q       <= '0;
            ip_q       <= '0;
            exc_code_q <= INT;
            epc_q      <= '0;
            take_q     <= 1'b0;
        end else begin
            ie_q       <= ie_d;
            exl_q      <= exl_d;
            im_q       <= im_d;
            ip_q       <= irq;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
            take_q     <= take_d;
        end
    end

    always_comb begin
        status_rd                          = '0;
        status_rd[IE]                      = ie_q;
        status_rd[EXL]                     = exl_q;
        status_rd[IM_LSB +: N_IRQ+1]       = im_q;
        cause_rd                           = '0;
        cause_rd[EXCCODE_LSB +: 5]         = exc_code_q;
        cause_rd[IP_LSB +: N_IRQ+1]        = {ti, ip_q};

        if (write_c0W && (writeregW == rd_sel)) begin
            c0D = resultW;
        end else begin
            case (rd_sel)
                CP0_COUNT:   c0D = count;
                CP0_COMPARE: c0D = compare;
                CP0_STATUS:  c0D = status_rd;
                CP0_CAUSE:   c0D = cause_rd;
                CP0_EPC:     c0D = epc_q;
                default:     c0D = '0;
            endcase
        end
    end

    assign take_exc    = take_q;
    assign exc_vector  = EXC_VECTOR;
    assign epc         = epc_q;
    assign kernel_mode = exl_q;

endmodule

// File: tb/tb_cp0_intc.sv
// Scenario bench for cp0_intc; take_exc pulses are matched against a queue of expected EPCs.
module tb_cp0_intc;
    import cp0_pkg::*;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned N_IRQ  = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              write_c0W = 1'b0;
    logic [4:0]        writeregW = '0;
    logic [DATA_W-1:0] resultW = '0;
    logic [4:0]        rd_sel = '0;
    logic [DATA_W-1:0] c0D;
    logic              exc_req = 1'b0;
    logic [4:0]        exc_code = '0;
    logic [DATA_W-1:0] exc_pc = '0;
    logic [DATA_W-1:0] int_pc = '0;
    logic [N_IRQ-1:0]  irq = '0;
    logic              eret = 1'b0;
    logic              take_exc;
    logic [DATA_W-1:0] exc_vector;
    logic [DATA_W-1:0] epc;
    logic              kernel_mode;

    int total = 0;
    int bad   = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic              prev_take = 1'b0;

    always #5 clk = ~clk;

    cp0_intc #(
        .DATA_W     (DATA_W),
        .N_IRQ      (N_IRQ),
        .EXC_VECTOR (32'h0000_0180),
        .TIMER_EN   (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .write_c0W   (write_c0W),
        .writeregW   (writeregW),
        .resultW     (resultW),
        .rd_sel      (rd_sel),
        .c0D         (c0D),
        .exc_req     (exc_req),
        .exc_code    (exc_code),
        .exc_pc      (exc_pc),
        .int_pc      (int_pc),
        .irq         (irq),
        .eret        (eret),
        .take_exc    (take_exc),
        .exc_vector  (exc_vector),
        .epc         (epc),
        .kernel_mode (kernel_mode)
    );

    // Every pulse must match the oldest expected event, last one cycle and redirect to the vector.
    always @(negedge clk) begin
        if (take_exc) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_take epc=%h want no pulse", epc);
            end else begin
                logic [DATA_W-1:0] e;
                e = exp_q.pop_front();
                if (epc !== e || kernel_mode !== 1'b1 || exc_vector !== 32'h0000_0180) begin
                    bad++;
                    $display("FAIL take_event epc=%h km=%b vec=%h want epc=%h km=1 vec=00000180",
                             epc, kernel_mode, exc_vector, e);
                end
            end
            total++;
            if (prev_take) begin
                bad++;
                $display("FAIL take_width got=2+ cycles want=1");
            end
        end
        prev_take = take_exc;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] idx, output logic [DATA_W-1:0] v);
        rd_sel = idx;
        #1;
        v = c0D;
    endtask

    task automatic set_wr(input logic [4:0] idx, input logic [DATA_W-1:0] val);
        write_c0W = 1'b1;
        writeregW = idx;
        resultW   = val;
    endtask

    task automatic clr_wr();
        write_c0W = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        irq   = '0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] v;
        reset = 1'b0;
        irq   = '1;
        tick();
        tick();
        total++;
        if (take_exc !== 1'b0 || kernel_mode !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags take=%b km=%b want 0 0", take_exc, kernel_mode);
        end
        rd(CP0_STATUS, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL reset_status got=%h want=0", v); end
        rd(CP0_CAUSE, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL reset_cause got=%h want=0", v); end
        rd(CP0_EPC, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL reset_epc got=%h want=0", v); end
        rd(CP0_COMPARE, v);
        total++;
        if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_compare got=%h want=ffffffff", v); end
        rd(CP0_COUNT, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL reset_count got=%h want=0", v); end
        irq   = '0;
        reset = 1'b1;
    endtask

    task automatic test_overflow();
        logic [DATA_W-1:0] v;
        exc_req  = 1'b1;
        exc_code = OV;
        exc_pc   = 32'h0000_0040;
        exp_q.push_back(32'h0000_0040);
        tick();
        exc_req = 1'b0;
        total++;
        if (take_exc !== 1'b1 || kernel_mode !== 1'b1) begin
            bad++;
            $display("FAIL ovf_take take=%b km=%b want 1 1", take_exc, kernel_mode);
        end
        rd(CP0_CAUSE, v);
        total++;
        if (v[6:2] !== 5'd12) begin bad++; $display("FAIL ovf_code got=%0d want=12", v[6:2]); end
        rd(CP0_EPC, v);
        total++;
        if (v !== 32'h40) begin bad++; $display("FAIL ovf_epc got=%h want=40", v); end
        tick();
        total++;
        if (take_exc !== 1'b0) begin bad++; $display("FAIL ovf_pulse_end got=%b want=0", take_exc); end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        total++;
        if (kernel_mode !== 1'b0) begin bad++; $display("FAIL ovf_eret km=%b want=0", kernel_mode); end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL ovf_drain got=%0d want=0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_masked_irq();
        logic [DATA_W-1:0] v;
        int_pc = 32'h0000_0200;
        set_wr(CP0_STATUS, 32'h0000_0101);
        irq[0] = 1'b1;
        exp_q.push_back(32'h0000_0200);
        tick();
        clr_wr();
        total++;
        if (take_exc !== 1'b0) begin bad++; $display("FAIL irq_early got=%b want=0", take_exc); end
        rd(CP0_CAUSE, v);
        total++;
        if (v[8] !== 1'b1) begin bad++; $display("FAIL irq_ip0 got=%b want=1", v[8]); end
        tick();
        total++;
        if (take_exc !== 1'b1) begin bad++; $display("FAIL irq_take got=%b want=1", take_exc); end
        rd(CP0_CAUSE, v);
        total++;
        if (v[6:2] !== 5'd0) begin bad++; $display("FAIL irq_code got=%0d want=0", v[6:2]); end
        rd(CP0_EPC, v);
        total++;
        if (v !== 32'h200) begin bad++; $display("FAIL irq_epc got=%h want=200", v); end
        irq = '0;
        tick();
        eret = 1'b1;
        tick();
        eret = 1'b0;
        total++;
        if (kernel_mode !== 1'b0) begin bad++; $display("FAIL irq_eret km=%b want=0", kernel_mode); end

        set_wr(CP0_STATUS, 32'h0000_0001);
        irq[0] = 1'b1;
        tick();
        clr_wr();
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (take_exc !== 1'b0) begin
                bad++;
                $display("FAIL irq_masked cyc=%0d got=%b want=0", i, take_exc);
            end
        end
        irq = '0;
        tick();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL irq_drain got=%0d want=0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_priority();
        logic [DATA_W-1:0] v;
        set_wr(CP0_STATUS, 32'h0000_0101);
        irq[0] = 1'b1;
        int_pc = 32'h0000_0210;
        tick();
        clr_wr();
        // Interrupt is pending this cycle; exception plus a Status write that tries to clear EXL.
        exc_req  = 1'b1;
        exc_code = SYS;
        exc_pc   = 32'h0000_0080;
        set_wr(CP0_STATUS, 32'h0000_0001);
        exp_q.push_back(32'h0000_0080);
        tick();
        exc_req = 1'b0;
        clr_wr();
        total++;
        if (take_exc !== 1'b1) begin bad++; $display("FAIL prio_take got=%b want=1", take_exc); end
        rd(CP0_CAUSE, v);
        total++;
        if (v[6:2] !== 5'd8) begin bad++; $display("FAIL prio_code got=%0d want=8", v[6:2]); end
        rd(CP0_STATUS, v);
        total++;
        if (v !== 32'h3) begin bad++; $display("FAIL prio_status got=%h want=3", v); end

        exc_req  = 1'b1;
        exc_code = OV;
        exc_pc   = 32'h0000_0099;
        tick();
        total++;
        if (take_exc !== 1'b0 || epc !== 32'h80) begin
            bad++;
            $display("FAIL nest_ignored take=%b epc=%h want 0 80", take_exc, epc);
        end
        rd(CP0_CAUSE, v);
        total++;
        if (v[6:2] !== 5'd8) begin bad++; $display("FAIL nest_code got=%0d want=8", v[6:2]); end

        irq  = '0;
        eret = 1'b1;
        tick();
        exc_req = 1'b0;
        eret    = 1'b0;
        total++;
        if (kernel_mode !== 1'b0 || take_exc !== 1'b0) begin
            bad++;
            $display("FAIL eret_vs_exc km=%b take=%b want 0 0", kernel_mode, take_exc);
        end
        tick();
        total++;
        if (take_exc !== 1'b0 || epc !== 32'h80) begin
            bad++;
            $display("FAIL eret_vs_exc_after take=%b epc=%h want 0 80", take_exc, epc);
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL prio_drain got=%0d want=0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_eret();
        logic [DATA_W-1:0] v;
        set_wr(CP0_STATUS, 32'h0000_0101);
        irq[0] = 1'b1;
        int_pc = 32'h0000_0300;
        exp_q.push_back(32'h0000_0300);
        tick();
        clr_wr();
        tick();
        total++;
        if (take_exc !== 1'b1) begin bad++; $display("FAIL eret_first got=%b want=1", take_exc); end
        tick();
        tick();
        total++;
        if (take_exc !== 1'b0 || kernel_mode !== 1'b1) begin
            bad++;
            $display("FAIL eret_blocked take=%b km=%b want 0 1", take_exc, kernel_mode);
        end
        exp_q.push_back(32'h0000_0300);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        total++;
        if (kernel_mode !== 1'b0 || take_exc !== 1'b0) begin
            bad++;
            $display("FAIL eret_clear km=%b take=%b want 0 0", kernel_mode, take_exc);
        end
        tick();
        total++;
        if (take_exc !== 1'b1 || kernel_mode !== 1'b1) begin
            bad++;
            $display("FAIL eret_retake take=%b km=%b want 1 1", take_exc, kernel_mode);
        end
        irq = '0;
        tick();
        eret = 1'b1;
        tick();
        eret = 1'b1;
        tick();
        eret = 1'b0;
        total++;
        if (kernel_mode !== 1'b0 || take_exc !== 1'b0) begin
            bad++;
            $display("FAIL eret_noop km=%b take=%b want 0 0", kernel_mode, take_exc);
        end
        rd(CP0_STATUS, v);
        total++;
        if (v !== 32'h101) begin bad++; $display("FAIL eret_status got=%h want=101", v); end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL eret_drain got=%0d want=0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_timer();
        logic [DATA_W-1:0] v;
        int n;
        do_reset();
        set_wr(CP0_STATUS, 32'h0000_4001);
        tick();
        set_wr(CP0_COMPARE, 32'd5);
        int_pc = 32'h0000_0400;
        exp_q.push_back(32'h0000_0400);
        tick();
        clr_wr();
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (take_exc) begin
                n = i;
                break;
            end
        end
        total++;
        if (n != 5) begin bad++; $display("FAIL timer_latency got=%0d want=5", n); end
        rd(CP0_CAUSE, v);
        total++;
        if (v[8+N_IRQ] !== 1'b1 || v[6:2] !== 5'd0) begin
            bad++;
            $display("FAIL timer_cause ti=%b code=%0d want 1 0", v[8+N_IRQ], v[6:2]);
        end
        rd(CP0_COUNT, v);
        total++;
        if (v !== 32'd7) begin bad++; $display("FAIL timer_count got=%0d want=7", v); end

        set_wr(CP0_COMPARE, 32'h0000_1000);
        tick();
        clr_wr();
        rd(CP0_CAUSE, v);
        total++;
        if (v[8+N_IRQ] !== 1'b0) begin bad++; $display("FAIL timer_ti_clear got=%b want=0", v[8+N_IRQ]); end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (take_exc !== 1'b0) begin bad++; $display("FAIL timer_quiet cyc=%0d got=%b want=0", i, take_exc); end
        end

        // Wrap with Compare elsewhere: no TI.
        set_wr(CP0_COUNT, 32'hFFFF_FFFE);
        tick();
        clr_wr();
        tick();
        tick();
        rd(CP0_COUNT, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL timer_wrap got=%h want=0", v); end
        rd(CP0_CAUSE, v);
        total++;
        if (v[8+N_IRQ] !== 1'b0) begin bad++; $display("FAIL timer_wrap_ti got=%b want=0", v[8+N_IRQ]); end

        // Wrap with Compare at all-ones: TI sets on the wrap edge.
        set_wr(CP0_COMPARE, 32'hFFFF_FFFF);
        tick();
        set_wr(CP0_COUNT, 32'hFFFF_FFFE);
        int_pc = 32'h0000_0500;
        exp_q.push_back(32'h0000_0500);
        tick();
        clr_wr();
        tick();
        rd(CP0_CAUSE, v);
        total++;
        if (v[8+N_IRQ] !== 1'b0) begin bad++; $display("FAIL timer_pre_match got=%b want=0", v[8+N_IRQ]); end
        tick();
        rd(CP0_CAUSE, v);
        total++;
        if (v[8+N_IRQ] !== 1'b1 || take_exc !== 1'b0) begin
            bad++;
            $display("FAIL timer_match ti=%b take=%b want 1 0", v[8+N_IRQ], take_exc);
        end
        tick();
        total++;
        if (take_exc !== 1'b1) begin bad++; $display("FAIL timer_match_take got=%b want=1", take_exc); end
        set_wr(CP0_COMPARE, 32'h0000_1000);
        tick();
        clr_wr();
        eret = 1'b1;
        tick();
        eret = 1'b0;
        tick();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL timer_drain got=%0d want=0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_bypass();
        logic [DATA_W-1:0] v;
        set_wr(CP0_EPC, 32'h0000_ABCD);
        rd(CP0_EPC, v);
        total++;
        if (v !== 32'hABCD) begin bad++; $display("FAIL bypass_epc got=%h want=abcd", v); end
        tick();
        clr_wr();
        total++;
        if (epc !== 32'hABCD) begin bad++; $display("FAIL epc_write got=%h want=abcd", epc); end
        set_wr(CP0_CAUSE, 32'hFFFF_FFFF);
        tick();
        clr_wr();
        rd(CP0_CAUSE, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL cause_ro got=%h want=0", v); end
        set_wr(5'd3, 32'h0000_1234);
        rd(5'd3, v);
        total++;
        if (v !== 32'h1234) begin bad++; $display("FAIL bypass_unmapped got=%h want=1234", v); end
        tick();
        clr_wr();
        rd(5'd3, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL unmapped_read got=%h want=0", v); end
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_masked_irq();
        test_priority();
        test_eret();
        test_timer();
        test_bypass();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cp0_intc.md
Name: cp0_intc

Overview:
- Parametrised successor to the single-cause coprocessor 0.
- Holds Status, Cause, EPC and a Count/Compare timer, and accepts N_IRQ level-sensitive external interrupt lines with per-line masking.
- Arbitrates synchronous exceptions against interrupts, and drives the PC redirect and kernel-mode flag to the pipeline.
- Sits beside the controller and regfile, with the same writeback-stage write port and decode-stage read port as today.

Parameters:
- DATA_W, 32, width of every CP0 register and data port.
- N_IRQ, 6, number of external interrupt lines; legal range 1..7 (timer takes the next IP slot).
- EXC_VECTOR, 32'h0000_0180, PC presented on exc_vector when an exception or interrupt is taken.
- TIMER_EN, 1, 0 removes Count/Compare; those registers then read 0 and TI never sets.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- write_c0W  in  1  mtc0 write strobe (writeback stage).
- writeregW  in  5  CP0 register index to write.
- resultW  in  DATA_W  write data.
- rd_sel  in  5  CP0 register index to read (decode stage, rt field).
- c0D  out  DATA_W  read data.
- exc_req  in  1  synchronous exception (overflow, syscall) this cycle.
- exc_code  in  5  ExcCode accompanying exc_req.
- exc_pc  in  DATA_W  PC of the faulting instruction.
- int_pc  in  DATA_W  PC to resume at after an interrupt.
- irq  in  N_IRQ  external interrupt lines, synchronous to clk, level-sensitive.
- eret  in  1  return-from-exception strobe.
- take_exc  out  1  one-cycle pulse: flush and load exc_vector.
- exc_vector  out  DATA_W  constant EXC_VECTOR.
- epc  out  DATA_W  current EPC, used as the eret target.
- kernel_mode  out  1  equals Status.EXL.

Behaviour:
- Register map:
  - 9 Count
  - 11 Compare
  - 12 Status: bit0 IE, bit1 EXL, bits[8+i] IM
  - 13 Cause: bits[6:2] ExcCode, bits[8+i] IP, bit[8+N_IRQ] timer TI
  - 14 EPC
  - Other indices read 0; writes to them are ignored. Cause is read-only to software.
- Reset (reset==0 at a rising edge):
  - Count=0, Compare=all-ones, Status=0, Cause=0, EPC=0.
  - take_exc=0, kernel_mode=0.
  - Reset has priority over every other event, including a pending take_exc; take_exc is low the cycle after reset.
- Read path:
  - c0D is combinational from rd_sel.
  - Write bypass: if write_c0W and writeregW==rd_sel, c0D=resultW.
- Timer:
  - Count increments by 1 every cycle and wraps all-ones to 0.
  - When Count==Compare (pre-increment value), TI sets on the next edge and stays sticky.
  - A write to Compare clears TI at the same edge.
  - A write to Count loads resultW in place of the increment.
- Interrupt pending:
  - IP[i] <= irq[i] every cycle (one register stage; reflects the level, not sticky).
- Interrupt condition: int_pend = IE & ~EXL & |({TI,IP} & IM[N_IRQ:0]).
- Taking an exception or interrupt (evaluated every cycle, registered):
  - If exc_req & ~EXL: EPC<=exc_pc, ExcCode<=exc_code, EXL<=1, take_exc=1 next cycle.
  - Else if int_pend: EPC<=int_pc, ExcCode<=0, EXL<=1, take_exc=1 next cycle.
  - exc_req always wins over an interrupt in the same cycle.
  - take_exc is high for exactly one cycle per event; EXL=1 blocks re-triggering.
- Nesting: exc_req while EXL=1 is ignored. EPC and ExcCode are unchanged and no take_exc pulse is issued.
- eret:
  - If EXL=1, clears EXL at the edge. If EXL=0, it is a no-op.
  - eret with exc_req in the same cycle while EXL=1: eret wins and the exception is ignored.
  - An interrupt still pending after eret is taken on the following cycle.
- mtc0 colliding with a hardware update at the same edge:
  - Hardware wins for EXL, ExcCode and EPC.
  - The software write applies to all other Status bits.
- Latency: event input to take_exc = 1 cycle; Status/EPC update is visible on c0D in that same cycle.

Decomposition:
- Shared package cp0_pkg holds:
  - Register index constants: CP0_COUNT, CP0_COMPARE, CP0_STATUS, CP0_CAUSE, CP0_EPC.
  - Bit-position constants: IE, EXL, IM_LSB, IP_LSB, EXCCODE_LSB.
  - exc_code_t enum: INT=0, SYS=8, OV=12.
- One sub-module, cp0_timer: Count/Compare registers, TI flag, write decode for indices 9/11.

Test Plan:
- Reset: hold reset=0 two cycles with irq=all-ones -> c0D=0 for Status/Cause/EPC, Compare reads 32'hFFFF_FFFF, take_exc=0.
- Overflow: exc_req=1, exc_code=12, exc_pc=32'h0000_0040 -> next cycle take_exc=1 for one cycle, EPC=32'h40, Cause[6:2]=12, kernel_mode=1.
- Masked IRQ:
  - Status=32'h0000_0101, irq[0]=1 -> take_exc two cycles later, ExcCode=0, EPC=int_pc.
  - Same with IM=0 -> no take_exc.
- Priority and nesting:
  - exc_req and unmasked irq in the same cycle -> ExcCode=exc_code, EPC=exc_pc.
  - A second exc_req while EXL=1 -> EPC unchanged, no pulse.
- Timer: write Compare=5 with Count at 0, IM[N_IRQ]=1, IE=1 -> TI sets, take_exc fires; writing Compare clears TI.
- eret: with EXL=1 and irq still asserted, pulse eret -> EXL=0, then take_exc one cycle later. Count wraps all-ones->0 without setting TI unless it equals Compare.
